// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
// The packet-lock option is enabled by defining RR_ARB_LOCK_EN.
package rr_arb_pkg;

  // Widest requester vector the index helper accepts.
  localparam int unsigned MAX_REQ = 32;

  typedef enum logic {
    IDLE,
    LOCKED
  } lock_state_e;

  // Index width for n requesters, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Binary index of the set bit in a one-hot vector (0 when empty).
  // Built as an OR of indices so it maps to a plain OR tree.
  function automatic int unsigned onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      idx = idx | (oh[i] ? i : 0);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: the first asserted request at or after
// ptr, wrapping modulo N_REQ. Rotate, isolate the lowest set bit, rotate back.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [2*N_REQ-1:0] req_dbl;
  logic [2*N_REQ-1:0] gnt_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [N_REQ-1:0]   gnt_rot;

  // Rotate requests so ptr lands on bit 0, keep the lowest one, rotate back.
  always_comb begin
    req_dbl = {req, req} >> ptr;
    req_rot = req_dbl[N_REQ-1:0];
    gnt_rot = req_rot & (~req_rot + N_REQ'(1));
    gnt_dbl = {gnt_rot, gnt_rot} << ptr;
    gnt     = gnt_dbl[2*N_REQ-1:N_REQ];
    idx     = IDX_W'(onehot_to_idx(MAX_REQ'(gnt)));
    any     = |req;
  end

endmodule

// File: rtl/rr_stream_arbiter.sv
// N_REQ-input round-robin arbiter feeding one registered valid/ready sink.
// Define RR_ARB_LOCK_EN to keep a requester granted until its t_last word.
module rr_stream_arbiter
  import rr_arb_pkg::*;
#(
  parameter int unsigned BIT_DEPTH = 8,
  parameter int unsigned N_REQ     = 4
) (
  input  logic                 clk,
  input  logic                 arstn,
  input  logic [BIT_DEPTH-1:0] t_data_i [N_REQ],
  input  logic [N_REQ-1:0]     t_valid_i,
  output logic [N_REQ-1:0]     t_ready_o,
`ifdef RR_ARB_LOCK_EN
  input  logic [N_REQ-1:0]     t_last_i,
  output logic                 t_last_o,
`endif
  output logic [BIT_DEPTH-1:0] t_data_o,
  output logic                 t_valid_o,
  input  logic                 t_ready_i,
  output logic [N_REQ-1:0]     grant_o
);

  localparam int unsigned IDX_W = idx_width(N_REQ);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_next;
  logic [IDX_W-1:0] pick_idx;
  logic [N_REQ-1:0] pick_req;
  logic [N_REQ-1:0] pick_gnt;
  logic             pick_any;
  logic             load_en;
  logic             xfer;
  logic             ptr_hold;

`ifdef RR_ARB_LOCK_EN
  lock_state_e      state;
  logic [IDX_W-1:0] lock_idx;
  logic             pick_last;

  // While a packet is open only its owner may compete.
  assign pick_req  = (state == LOCKED) ? (t_valid_i & (N_REQ'(1) << lock_idx)) : t_valid_i;
  assign pick_last = t_last_i[pick_idx];
  assign ptr_hold  = (state == LOCKED) && !pick_last;

  // Packet lock FSM: open on a non-last word, close on the owner's last word.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state    <= IDLE;
      lock_idx <= '0;
    end else if (xfer) begin
      case (state)
        IDLE: begin
          if (!pick_last) begin
            state    <= LOCKED;
            lock_idx <= pick_idx;
          end
        end
        LOCKED: begin
          if (pick_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Last flag travels with the word in the output register.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn)    t_last_o <= 1'b0;
    else if (xfer) t_last_o <= pick_last;
  end
`else
  assign pick_req = t_valid_i;
  assign ptr_hold = 1'b0;
`endif

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req (pick_req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // The output register can take a word when empty or draining this cycle.
  // NOTE: ready is derived from valids and register state only, never from
  // t_data_i, so upstream may compute data late without creating a loop.
  assign load_en   = !t_valid_o || t_ready_i;
  assign xfer      = load_en && pick_any;
  assign t_ready_o = pick_gnt & {N_REQ{load_en}};
  assign ptr_next  = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);

  // Round-robin pointer moves past each winner unless a packet holds it.
  // NOTE: registers use non-blocking assignment so every flop samples the
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn)                 ptr <= '0;
    else if (xfer && !ptr_hold) ptr <= ptr_next;
  end

  // One-entry output register: load on accept, empty on drain, hold on stall.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      t_data_o  <= '0;
      t_valid_o <= 1'b0;
      grant_o   <= '0;
    end else if (xfer) begin
      t_data_o  <= t_data_i[pick_idx];
      t_valid_o <= 1'b1;
      grant_o   <= pick_gnt;
    end else if (t_valid_o && t_ready_i) begin
      t_valid_o <= 1'b0;
      grant_o   <= '0;
    end
  end

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Directed bench for rr_stream_arbiter (BIT_DEPTH=8, N_REQ=4).
// Packet-lock steps run only when RR_ARB_LOCK_EN is defined.
module tb_rr_stream_arbiter;

  localparam int unsigned BIT_DEPTH = 8;
  localparam int unsigned N_REQ     = 4;

  logic                 clk = 1'b0;
  logic                 arstn;
  logic [BIT_DEPTH-1:0] t_data_i [N_REQ];
  logic [N_REQ-1:0]     t_valid_i;
  logic [N_REQ-1:0]     t_ready_o;
  logic [BIT_DEPTH-1:0] t_data_o;
  logic                 t_valid_o;
  logic                 t_ready_i;
  logic [N_REQ-1:0]     grant_o;
`ifdef RR_ARB_LOCK_EN
  logic [N_REQ-1:0]     t_last_i;
  logic                 t_last_o;
`endif

  int tests = 0;
  int fails = 0;

  rr_stream_arbiter #(
    .BIT_DEPTH (BIT_DEPTH),
    .N_REQ     (N_REQ)
  ) dut (
    .clk       (clk),
    .arstn     (arstn),
    .t_data_i  (t_data_i),
    .t_valid_i (t_valid_i),
    .t_ready_o (t_ready_o),
`ifdef RR_ARB_LOCK_EN
    .t_last_i  (t_last_i),
    .t_last_o  (t_last_o),
`endif
    .t_data_o  (t_data_o),
    .t_valid_o (t_valid_o),
    .t_ready_i (t_ready_i),
    .grant_o   (grant_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [7:0] data, input logic valid,
                           input logic [3:0] gnt);
    check({tag, "_data"},  32'(t_data_o),  32'(data));
    check({tag, "_valid"}, 32'(t_valid_o), 32'(valid));
    check({tag, "_grant"}, 32'(grant_o),   32'(gnt));
  endtask

  task automatic check_rdy(input string tag, input logic [3:0] rdy);
    #1;
    check({tag, "_ready"}, 32'(t_ready_o), 32'(rdy));
  endtask

  logic [7:0] rot_data [5] = '{8'd7, 8'd15, 8'd23, 8'd31, 8'd7};
  logic [3:0] rot_rdy  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    t_data_i[0] = 8'd7;
    t_data_i[1] = 8'd15;
    t_data_i[2] = 8'd23;
    t_data_i[3] = 8'd31;
    t_valid_i   = '0;
    t_ready_i   = 1'b1;
`ifdef RR_ARB_LOCK_EN
    t_last_i    = '1;
`endif
    arstn       = 1'b0;

    // Power-on reset.
    repeat (2) tick();
    check_out("por", 8'd0, 1'b0, 4'b0000);
    check_rdy("por", 4'b0000);
    arstn = 1'b1;

    // All valid, sink always ready: rotate 0,1,2,3,0.
    t_valid_i = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      check_rdy($sformatf("rot%0d", i), rot_rdy[i]);
      tick();
      check_out($sformatf("rot%0d", i), rot_data[i], 1'b1, rot_rdy[i]);
    end

    // Asynchronous reset mid-run clears outputs in the same cycle.
    arstn = 1'b0;
    #1;
    check_out("arst", 8'd0, 1'b0, 4'b0000);
    tick();
    arstn = 1'b1;

    // Stall: first load is req0, then sink blocks for 3 cycles.
    t_ready_i = 1'b0;
    check_rdy("stall_load", 4'b0001);
    tick();
    check_out("stall_load", 8'd7, 1'b1, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      check_rdy($sformatf("stall%0d", i), 4'b0000);
      tick();
      check_out($sformatf("stall%0d", i), 8'd7, 1'b1, 4'b0001);
    end
    t_ready_i = 1'b1;
    check_rdy("stall_rel", 4'b0010);
    tick();
    check_out("stall_rel", 8'd15, 1'b1, 4'b0010);

    // Lone requester granted every cycle, then drain to empty.
    t_valid_i = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      check_rdy($sformatf("lone%0d", i), 4'b0001);
      tick();
      check_out($sformatf("lone%0d", i), 8'd7, 1'b1, 4'b0001);
    end
    t_valid_i = 4'b0000;
    check_rdy("drain", 4'b0000);
    tick();
    check_out("drain", 8'd7, 1'b0, 4'b0000);

    // req3 alone, then all valid: pointer wraps to req0 then req1.
    t_valid_i = 4'b1000;
    check_rdy("wrap3", 4'b1000);
    tick();
    check_out("wrap3", 8'd31, 1'b1, 4'b1000);
    t_valid_i = 4'b1111;
    check_rdy("wrap0", 4'b0001);
    tick();
    check_out("wrap0", 8'd7, 1'b1, 4'b0001);
    check_rdy("wrap1", 4'b0010);
    tick();
    check_out("wrap1", 8'd15, 1'b1, 4'b0010);

`ifdef RR_ARB_LOCK_EN
    // Bring pointer to req1, then req1 sends a 3-word packet while req0 waits.
    t_valid_i = 4'b0001;
    tick();
    check_out("lk_prep", 8'd7, 1'b1, 4'b0001);
    t_valid_i = 4'b0011;
    t_last_i  = 4'b1101;
    for (int i = 0; i < 2; i++) begin
      check_rdy($sformatf("lk%0d", i), 4'b0010);
      tick();
      check_out($sformatf("lk%0d", i), 8'd15, 1'b1, 4'b0010);
      check($sformatf("lk%0d_last", i), 32'(t_last_o), 32'd0);
    end
    t_last_i = 4'b1111;
    check_rdy("lk2", 4'b0010);
    tick();
    check_out("lk2", 8'd15, 1'b1, 4'b0010);
    check("lk2_last", 32'(t_last_o), 32'd1);
    check_rdy("lk_after", 4'b0001);
    tick();
    check_out("lk_after", 8'd7, 1'b1, 4'b0001);
    check("lk_after_last", 32'(t_last_o), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
